// File: rtl/round_scorer_if.sv
// Signal bundle between the digit-entry/compare FSM, the round scorer and its display/LED consumers.
// All signals are plain levels or one-cycle pulses; there is no valid/ready pairing.
interface round_scorer_if;
  logic        start;
  logic        checking;
  logic        match;
  logic [7:0]  secs_bcd;
  logic [11:0] score_bcd;
  logic        round_active;
  logic        win;
  logic        timeout;
  logic [2:0]  state;

  modport master (
    output start, checking, match,
    input  secs_bcd, score_bcd, round_active, win, timeout, state
  );

  modport slave (
    input  start, checking, match,
    output secs_bcd, score_bcd, round_active, win, timeout, state
  );
endinterface

// File: rtl/round_scorer.sv
// Per-round countdown with stable-match qualification; awards remaining seconds
// to a saturating 3-digit BCD score and pulses win/timeout.
module round_scorer #(
  parameter int TICK_DIV      = 50000000,
  parameter int ROUND_SECONDS = 30,
  parameter int MATCH_STABLE  = 1000
) (
  input  logic          clk,
  input  logic          resetn,
  round_scorer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    RUN   = 3'd2,
    WIN   = 3'd3,
    LOSE  = 3'd4
  } state_e;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (MATCH_STABLE > 0) ? $clog2(MATCH_STABLE + 1) : 1;
  localparam logic [7:0] SECS_INIT = {4'(ROUND_SECONDS / 10), 4'(ROUND_SECONDS % 10)};

  state_e          state_q;
  logic            start_q;
  logic [7:0]      secs_q;
  logic [7:0]      secs_d;
  logic [11:0]     score_q;
  logic [11:0]     score_d;
  logic [PW-1:0]   presc_q;
  logic [SW-1:0]   stable_q;
  logic            win_q;
  logic            timeout_q;

  logic            start_rise;
  logic            tick;
  logic            win_hit;
  logic            last_sec;
  logic [4:0]      d0, d1, d2;
  logic            c0, c1;

  always_comb begin
    start_rise = bus.start & ~start_q;
    tick       = (presc_q == PW'(TICK_DIV - 1));
    win_hit    = bus.match && (stable_q == SW'(MATCH_STABLE - 1));
    last_sec   = (secs_q == 8'h01);

    secs_d = secs_q;
    if (secs_q[3:0] == 4'd0) secs_d = {secs_q[7:4] - 4'd1, 4'd9};
    else                     secs_d = {secs_q[7:4], secs_q[3:0] - 4'd1};

    // Digit-serial BCD add of the pre-decrement seconds, clamped at 999.
    d0 = {1'b0, score_q[3:0]} + {1'b0, secs_q[3:0]};
    c0 = (d0 > 5'd9);
    if (c0) d0 = d0 - 5'd10;
    d1 = {1'b0, score_q[7:4]} + {1'b0, secs_q[7:4]} + {4'd0, c0};
    c1 = (d1 > 5'd9);
    if (c1) d1 = d1 - 5'd10;
    d2 = {1'b0, score_q[11:8]} + {4'd0, c1};
    if (d2 > 5'd9) score_d = 12'h999;
    else           score_d = {d2[3:0], d1[3:0], d0[3:0]};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      secs_q    <= SECS_INIT;
      score_q   <= '0;
      presc_q   <= '0;
      stable_q  <= '0;
      win_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      start_q   <= bus.start;
      win_q     <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_rise) begin
            state_q <= ARMED;
            secs_q  <= SECS_INIT;
          end
        end
        ARMED: begin
          if (bus.checking) begin
            state_q  <= RUN;
            presc_q  <= '0;
            stable_q <= '0;
          end
        end
        RUN: begin
          presc_q <= tick ? '0 : presc_q + 1'b1;
          if (!bus.match)                           stable_q <= '0;
          else if (stable_q != SW'(MATCH_STABLE))   stable_q <= stable_q + 1'b1;
          // A win on the final tick takes priority: score the 01, keep secs, no timeout.
          if (win_hit) begin
            state_q <= WIN;
            score_q <= score_d;
            win_q   <= 1'b1;
          end else if (!bus.checking) begin
            state_q <= IDLE;
            secs_q  <= SECS_INIT;
          end else if (tick) begin
            secs_q <= secs_d;
            if (last_sec) begin
              state_q   <= LOSE;
              timeout_q <= 1'b1;
            end
          end
        end
        WIN, LOSE: begin
          if (start_rise) begin
            state_q <= ARMED;
            secs_q  <= SECS_INIT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.secs_bcd     = secs_q;
  assign bus.score_bcd    = score_q;
  assign bus.win          = win_q;
  assign bus.timeout      = timeout_q;
  assign bus.state        = state_q;
  assign bus.round_active = (state_q == RUN);

endmodule

// File: tb/tb_round_scorer.sv
// Bench for round_scorer: directed rounds with literal expectations plus random
// stimulus, all compared each cycle against an integer-level model of a round.
module tb_round_scorer;
  localparam int TD = 4;
  localparam int RS = 5;
  localparam int MS = 3;

  // clock / reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  round_scorer_if bus();

  round_scorer #(
    .TICK_DIV(TD),
    .ROUND_SECONDS(RS),
    .MATCH_STABLE(MS)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [11:0] bcd3(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Round model: seconds left = RS minus completed TICK_DIV periods in RUN,
  // win once MS consecutive match-high RUN cycles accumulate.
  int m_state, m_secs, m_score, m_streak, m_run_cyc;
  bit m_win, m_to, m_start_prev, m_rise, m_tick, model_valid;
  logic [11:0] sb_exp;

  always @(posedge clk) begin
    if (!resetn) begin
      m_state = 0; m_secs = RS; m_score = 0; m_streak = 0; m_run_cyc = 0;
      m_win = 0; m_to = 0; m_start_prev = 0; model_valid = 1;
    end else begin
      m_rise = bus.start && !m_start_prev;
      m_start_prev = bus.start;
      m_win = 0;
      m_to = 0;
      case (m_state)
        0: if (m_rise) begin m_state = 1; m_secs = RS; end
        1: if (bus.checking) begin m_state = 2; m_run_cyc = 0; m_streak = 0; end
        2: begin
          m_run_cyc++;
          m_tick = (m_run_cyc % TD) == 0;
          m_streak = bus.match ? m_streak + 1 : 0;
          if (m_streak >= MS) begin
            m_state = 3;
            m_score = (m_score + m_secs > 999) ? 999 : m_score + m_secs;
            m_win = 1;
            exp_q.push_back(bcd3(m_score));
          end else if (!bus.checking) begin
            m_state = 0;
            m_secs = RS;
          end else if (m_tick) begin
            m_secs--;
            if (m_secs == 0) begin m_state = 4; m_to = 1; end
          end
        end
        default: if (m_rise) begin m_state = 1; m_secs = RS; end
      endcase
    end
    #1;
    if (model_valid) begin
      check("state", 32'(bus.state), 32'(m_state));
      check("secs_bcd", 32'(bus.secs_bcd), 32'(bcd2(m_secs)));
      check("score_bcd", 32'(bus.score_bcd), 32'(bcd3(m_score)));
      check("round_active", 32'(bus.round_active), 32'(m_state == 2));
      check("win", 32'(bus.win), 32'(m_win));
      check("timeout", 32'(bus.timeout), 32'(m_to));
      if (bus.win === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL win_sb: unexpected win pulse with score %0h", bus.score_bcd);
        end else begin
          sb_exp = exp_q.pop_front();
          check("win_sb_score", 32'(bus.score_bcd), 32'(sb_exp));
        end
      end
    end
  end

  // driver tasks
  task automatic start_round();
    @(negedge clk);
    bus.start = 1'b1;
    bus.checking = 1'b1;
    bus.match = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic play(input int n, input logic [31:0] mask);
    start_round();
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      bus.match = mask[k-1];
    end
    @(negedge clk);
    bus.match = 1'b0;
  endtask

  initial begin
    int mode;
    bus.start = 1'b0;
    bus.checking = 1'b0;
    bus.match = 1'b0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_secs", 32'(bus.secs_bcd), 32'h05);
    check("rst_score", 32'(bus.score_bcd), 32'h000);
    check("rst_win", 32'(bus.win), 32'd0);
    check("rst_timeout", 32'(bus.timeout), 32'd0);
    resetn = 1'b1;

    play(20, 32'h0);
    check("lose_state", 32'(bus.state), 32'd4);
    check("lose_secs", 32'(bus.secs_bcd), 32'h00);
    check("lose_score", 32'(bus.score_bcd), 32'h000);

    play(11, 32'h0000_0700);
    check("win3_state", 32'(bus.state), 32'd3);
    check("win3_score", 32'(bus.score_bcd), 32'h003);

    play(3, 32'h7);
    check("win5_score", 32'(bus.score_bcd), 32'h008);

    play(6, 32'h3B);
    check("glitch_state", 32'(bus.state), 32'd3);
    check("glitch_score", 32'(bus.score_bcd), 32'h012);

    play(20, 32'h000E_0000);
    check("tie_state", 32'(bus.state), 32'd3);
    check("tie_secs", 32'(bus.secs_bcd), 32'h01);
    check("tie_score", 32'(bus.score_bcd), 32'h013);

    for (int r = 0; r < 197; r++) play(3, 32'h7);
    check("pre_sat_score", 32'(bus.score_bcd), 32'h998);
    play(3, 32'h7);
    check("sat_score", 32'(bus.score_bcd), 32'h999);

    play(5, 32'h0);
    bus.checking = 1'b0;
    @(negedge clk);
    check("drop_state", 32'(bus.state), 32'd0);
    check("drop_secs", 32'(bus.secs_bcd), 32'h05);
    check("drop_score", 32'(bus.score_bcd), 32'h999);

    play(6, 32'h0);
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_state", 32'(bus.state), 32'd0);
    check("midrst_secs", 32'(bus.secs_bcd), 32'h05);
    check("midrst_score", 32'(bus.score_bcd), 32'h000);
    check("midrst_win", 32'(bus.win), 32'd0);
    check("midrst_timeout", 32'(bus.timeout), 32'd0);
    resetn = 1'b1;

    // random phase
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c % 64 == 0) mode = $urandom_range(0, 2);
      resetn = ($urandom_range(0, 299) != 0);
      bus.start = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 49) == 0) bus.checking = ~bus.checking;
      case (mode)
        0:       bus.match = bus.checking && ($urandom_range(0, 7) == 0);
        1:       bus.match = bus.checking && ($urandom_range(0, 3) != 0);
        default: bus.match = bus.checking && ($urandom_range(0, 1) == 0);
      endcase
    end
    @(negedge clk);
    resetn = 1'b1;
    bus.start = 1'b0;
    bus.match = 1'b0;
    @(negedge clk);
    check("win_sb_drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/round_scorer.md
Name: round_scorer

Overview:
- Downstream of the digit-entry/compare FSM; consumes its check-phase flag (chk_seq) and answer-match flag.
- Runs a per-round countdown timer and qualifies a stable match.
- Awards points equal to the seconds remaining and keeps a running 3-digit BCD score.
- Drives the seconds and score digits to spare hex decoders and issues win/timeout pulses to LEDs.

Parameters:
- TICK_DIV, 50000000, clk cycles per one-second tick (≥2)
- ROUND_SECONDS, 30, countdown start value in seconds (1..99)
- MATCH_STABLE, 1000, consecutive cycles match must be high to count as a win (≥1)

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- start  in  1  level; rising edge arms a round (go button)
- checking  in  1  level; high while the upstream FSM is in its check phase
- match  in  1  level; high when switches equal the converted answer and checking is high
- secs_bcd  out  8  remaining seconds, two BCD digits [7:4] tens, [3:0] ones
- score_bcd  out  12  total score, three BCD digits, [11:8] hundreds
- round_active  out  1  high in RUN
- win  out  1  one-cycle pulse on win
- timeout  out  1  one-cycle pulse on loss
- state  out  3  current FSM state, for LED debug

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state=IDLE, secs_bcd=BCD(ROUND_SECONDS), score_bcd=0, prescaler=0, stable counter=0.
  - win=0, timeout=0, start edge register=0.
  - Reset mid-round discards the round; no pulses are issued.
- start edge: start_q registered every cycle; start_rise = start & ~start_q.
- States and encoding: IDLE=0, ARMED=1, RUN=2, WIN=3, LOSE=4. All other codes go to IDLE on the next cycle.
- IDLE: start_rise → ARMED; secs_bcd reloaded to ROUND_SECONDS.
- ARMED: checking=1 → RUN; prescaler and stable counter cleared on entry.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - On the wrap cycle, secs_bcd decrements in BCD: ones 0 → 9 with tens-1.
  - Stable counter increments while match=1 and clears to 0 whenever match=0. It saturates at MATCH_STABLE.
  - Win condition: the stable counter reaches MATCH_STABLE, so the counter equals MATCH_STABLE-1 and match=1 this cycle.
    - Next state WIN.
    - score_bcd += secs_bcd (pre-decrement value), BCD addition saturating at 999.
    - win=1 for exactly one cycle, registered with the state change.
  - Timeout condition: a tick occurs while secs_bcd=01.
    - secs_bcd becomes 00, next state LOSE, timeout=1 for one cycle.
  - Simultaneous win and timeout on the same cycle: win wins.
    - The score adds 01.
    - secs_bcd is not decremented.
    - No timeout pulse.
  - checking drops to 0 without a win → IDLE. No score change, no pulse, secs_bcd reloaded.
- WIN / LOSE:
  - secs_bcd and score_bcd held.
  - start_rise → ARMED with secs_bcd reloaded.
  - score_bcd persists across rounds; only resetn clears it.
- round_active = (state==RUN), combinational from the state register.
- Latency:
  - Win pulse asserts on the edge after the MATCH_STABLE-th consecutive match-high cycle.
  - The first tick occurs TICK_DIV cycles after RUN entry.
- A match before RUN (IDLE/ARMED) or after a round ends is ignored.
- All outputs are registered except round_active and state (state is the register itself).

Test Plan (bench parameters TICK_DIV=4, ROUND_SECONDS=5, MATCH_STABLE=3):
- Reset → IDLE, score_bcd=000, secs_bcd=05, win=timeout=0. Assert resetn=0 mid-RUN → same values next cycle, no pulse.
- start pulse, checking=1, match held low → secs_bcd steps 05,04,03,02,01,00 at 4-cycle intervals. timeout pulses once when 00 is reached, state=LOSE, score_bcd=000.
- New round, match=1 for 3 cycles starting at cycle 9 after RUN entry (secs=03) → win pulse once, state=WIN, score_bcd=003. A second round won at secs=05 → score_bcd=008.
- match pattern 1,1,0,1,1,1 → win only after the final three consecutive highs; the glitch resets the stable counter.
- Win qualification on the same cycle as the tick at secs=01 → WIN, score +1, secs_bcd stays 01, no timeout pulse.
- Score preloaded to 998 via repeated wins, then a win at secs=05 → score_bcd saturates at 999. checking dropped mid-RUN → IDLE, secs_bcd=05, score unchanged.
